// File: rtl/enc_scan.sv
//----------------------------------------------------------------------------
// enc_scan
//   Sequential set-bit scanner: captures an N-bit request vector and emits
//   the index of each set bit, one per beat, over a valid/ready stream.
//   Optional macro ENC_SCAN_COUNT_EN adds out_cnt (popcount of the vector).
//   Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module enc_scan #(
  parameter int WIDTH     = 10,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
`ifdef ENC_SCAN_COUNT_EN
  , localparam int CNT_W  = $clog2(WIDTH + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty
`ifdef ENC_SCAN_COUNT_EN
  , output logic [CNT_W-1:0] out_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [WIDTH-1:0]   r_pend;
  logic [WIDTH-1:0]   w_pend_n;
  logic               r_empty;
  logic               w_empty_n;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last;
  logic               w_accept;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_clear;

  // Index of the next bit to emit; the last match in scan order wins, so
  // scanning upward yields the highest bit and scanning downward the lowest.
  function automatic logic [IDX_W-1:0] f_pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) r = IDX_W'(i);
      end else begin
        if (v[WIDTH-1-i]) r = IDX_W'(WIDTH-1-i);
      end
    end
    return r;
  endfunction

  assign out_valid = (r_state == ST_EMIT);
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign out_empty = r_empty;

  // A new vector may enter while idle or in the cycle the final beat leaves.
  assign in_ready  = !rst & ((r_state == ST_IDLE) | (out_valid & out_ready & out_last));
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;
  assign w_clear   = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;

  // Next pending set and state: capture wins over drain on the last beat.
  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_empty_n = r_empty;
    if (w_accept) begin
      w_state_n = ST_EMIT;
      w_pend_n  = in_vec;
      w_empty_n = (in_vec == '0);
    end else if (w_xfer) begin
      w_pend_n = r_pend & ~w_clear;
      if (r_last) begin
        w_state_n = ST_IDLE;
        w_empty_n = 1'b0;
      end
    end
  end

  // State, pending bits and registered beat fields (held while stalled).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_empty <= 1'b0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_empty <= w_empty_n;
      if (w_state_n == ST_EMIT) begin
        r_idx  <= f_pick(w_pend_n);
        r_last <= ((w_pend_n & (w_pend_n - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
      end else begin
        r_idx  <= '0;
        r_last <= 1'b0;
      end
    end
  end

`ifdef ENC_SCAN_COUNT_EN
  function automatic logic [CNT_W-1:0] f_popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  logic [CNT_W-1:0] r_cnt;

  // Popcount latched at capture, constant across the vector's beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= f_popcnt(in_vec);
    end
  end

  assign out_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enc_scan.sv
//----------------------------------------------------------------------------
// tb_enc_scan
//   Self-checking bench for enc_scan: table-driven vectors, directed
//   multi-cycle sequences and randomized traffic against a beat-queue model.
//   Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_enc_scan;

  localparam int W   = 10;
  localparam int IW  = 4;
  localparam bit MSB = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_empty;
`ifdef ENC_SCAN_COUNT_EN
  logic [3:0]    out_cnt;
`endif

  always #5 clk = ~clk;

  enc_scan #(.WIDTH(W), .IDX_W(IW), .MSB_FIRST(MSB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty)
`ifdef ENC_SCAN_COUNT_EN
    , .out_cnt (out_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the ordered list of beats a vector must produce.
  typedef struct {
    int idx;
    bit last;
    bit empty;
    int cnt;
  } beat_t;

  beat_t q[$];

  function automatic void model_push(input logic [W-1:0] v);
    beat_t b;
    int    n;
    int    k;
    int    i;
    n = $countones(v);
    if (n == 0) begin
      b.idx = 0; b.last = 1'b1; b.empty = 1'b1; b.cnt = 0;
      q.push_back(b);
      return;
    end
    k = 0;
    for (int j = 0; j < W; j++) begin
      i = MSB ? (W - 1 - j) : j;
      if (v[i]) begin
        k++;
        b.idx = i; b.last = (k == n); b.empty = 1'b0; b.cnt = n;
        q.push_back(b);
      end
    end
  endfunction

  // Directed vectors with hand-derived beat sequences (ascending order).
  typedef struct {
    logic [W-1:0] vec;
    int           n;
    int           idx[10];
    bit           empty;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t t);
    in_vec    = t.vec;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("tbl_in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_vec   = W'($urandom);
    #1;
    for (int b = 0; b < t.n; b++) begin
      chk("tbl_valid", out_valid, 1);
      chk("tbl_idx", out_idx, t.idx[b]);
      chk("tbl_last", out_last, (b == t.n - 1));
      chk("tbl_empty", out_empty, t.empty);
`ifdef ENC_SCAN_COUNT_EN
      chk("tbl_cnt", out_cnt, t.empty ? 0 : t.n);
`endif
      if (b == t.n - 1) chk("tbl_in_ready_last", in_ready, 1);
      tick();
    end
    chk("tbl_valid_after", out_valid, 0);
  endtask

  bit           prev_stall = 1'b0;
  logic [IW-1:0] prev_idx;
  logic          prev_last;
  logic          prev_empty;

  // One randomized cycle: compare the DUT against the beat queue, then clock.
  task automatic rcycle(input bit iv, input logic [W-1:0] v, input bit ordy);
    beat_t e;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    #1;
    chk("r_valid", out_valid, (q.size() != 0));
    chk("r_in_ready", in_ready, (q.size() == 0) || (ordy && q.size() == 1));
    if (prev_stall) begin
      chk("r_hold_valid", out_valid, 1);
      chk("r_hold_idx", out_idx, prev_idx);
      chk("r_hold_last", out_last, prev_last);
      chk("r_hold_empty", out_empty, prev_empty);
    end
    if (out_valid && ordy && q.size() != 0) begin
      e = q.pop_front();
      chk("r_idx", out_idx, e.idx);
      chk("r_last", out_last, e.last);
      chk("r_empty", out_empty, e.empty);
`ifdef ENC_SCAN_COUNT_EN
      chk("r_cnt", out_cnt, e.cnt);
`endif
    end
    if (iv && in_ready) model_push(v);
    prev_stall = out_valid && !ordy;
    prev_idx   = out_idx;
    prev_last  = out_last;
    prev_empty = out_empty;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    // Reset for two cycles; in_ready must be low while rst is high.
    tick();
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_empty", out_empty, 0);
    chk("rst_in_ready_after", in_ready, 1);
`ifdef ENC_SCAN_COUNT_EN
    chk("rst_cnt", out_cnt, 0);
`endif

    tbl[0].vec = 10'b00_0000_0100; tbl[0].n = 1;  tbl[0].empty = 1'b0;
    tbl[0].idx = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].vec = 10'b10_0001_0010; tbl[1].n = 3;  tbl[1].empty = 1'b0;
    tbl[1].idx = '{1, 4, 9, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].vec = 10'b00_0000_0000; tbl[2].n = 1;  tbl[2].empty = 1'b1;
    tbl[2].idx = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].vec = 10'h3FF;          tbl[3].n = 10; tbl[3].empty = 1'b0;
    tbl[3].idx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[4].vec = 10'b10_0000_0000; tbl[4].n = 1;  tbl[4].empty = 1'b0;
    tbl[4].idx = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].vec = 10'b00_0000_0001; tbl[5].n = 1;  tbl[5].empty = 1'b0;
    tbl[5].idx = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6].vec = 10'b01_0101_0101; tbl[6].n = 5;  tbl[6].empty = 1'b0;
    tbl[6].idx = '{0, 2, 4, 6, 8, 0, 0, 0, 0, 0};

    for (int k = 0; k < 7; k++) run_vec(tbl[k]);

    // Stall: first beat held for three cycles, then both beats drain.
    in_vec    = 10'b00_0000_0011;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_idx", out_idx, 0);
      chk("stall_last", out_last, 0);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_b0_idx", out_idx, 0);
    chk("stall_b0_last", out_last, 0);
    tick();
    chk("stall_b1_idx", out_idx, 1);
    chk("stall_b1_last", out_last, 1);
    tick();
    chk("stall_done", out_valid, 0);

    // Back-to-back: B is captured as A's last beat leaves, no idle cycle.
    in_vec   = 10'b00_0000_0001;
    in_valid = 1'b1;
    tick();
    in_vec = 10'b00_0000_0100;
    #1;
    chk("b2b_a_valid", out_valid, 1);
    chk("b2b_a_idx", out_idx, 0);
    chk("b2b_a_last", out_last, 1);
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_b_valid", out_valid, 1);
    chk("b2b_b_idx", out_idx, 2);
    chk("b2b_b_last", out_last, 1);
    tick();
    chk("b2b_done", out_valid, 0);

    // Reset mid-burst after two transferred beats.
    in_vec   = 10'h3FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef ENC_SCAN_COUNT_EN
    chk("mid_cnt_burst", out_cnt, 10);
`endif
    tick();
    tick();
    chk("mid_b2_idx", out_idx, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid_after_rst", out_valid, 0);
    chk("mid_idx_after_rst", out_idx, 0);
`ifdef ENC_SCAN_COUNT_EN
    chk("mid_cnt_after_rst", out_cnt, 0);
`endif
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("mid_no_beats", out_valid, 0);
    end

    // Randomized traffic against the beat-queue model.
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = W'(1) << $urandom_range(0, W - 1);
        default: v = W'($urandom);
      endcase
      rcycle($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0);
    end

    // Drain remaining beats within a bounded number of cycles.
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      rcycle(1'b0, W'($urandom), 1'b1);
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
